dpd_delay_est: RTL and testbench

//  Loop-delay estimator feeding the DPD core's DELAY compensation. On start, captures one burst of

---
 rtl/dpd_delay_est_if.sv | 18 +
 rtl/dpd_delay_est.sv | 182 ++++++++++++++++++
 tb/tb_dpd_delay_est.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dpd_delay_est_if.sv
// Sample taps and result bus of the DPD loop-delay estimator.
interface dpd_delay_est_if #(parameter int W = 20);
  logic                start;
  logic signed [W-1:0] ref_i;
  logic signed [W-1:0] ref_q;
  logic signed [W-1:0] fb_i;
  logic signed [W-1:0] fb_q;
  logic                busy;
  logic                done;
  logic                fail;
  logic [7:0]          delay_out;
  logic signed [31:0]  peak_out;

  modport master (output start, ref_i, ref_q, fb_i, fb_q,
                  input  busy, done, fail, delay_out, peak_out);
  modport slave  (input  start, ref_i, ref_q, fb_i, fb_q,
                  output busy, done, fail, delay_out, peak_out);
endinterface

// File: rtl/dpd_delay_est.sv
// Loop-delay estimator: captures a ref/feedback burst, then finds the lag with the
// largest Re(sum ref[n]*conj(fb[n+lag])) and reports it as the DPD delay.
module dpd_delay_est #(
  parameter int                 W             = 20,
  parameter int                 N             = 64,
  parameter int                 MAX_LAG       = 63,
  parameter int                 DEFAULT_DELAY = 41,
  parameter logic signed [31:0] THRESH        = 32'sd0
) (
  input  logic            clk,
  input  logic            reset_b,
  dpd_delay_est_if.slave  est
);
  // state     | meaning
  // S_IDLE    | waiting for start; start sample is capture index 0
  // S_CAPTURE | writing ref[0..N-1] and fb[0..N+MAX_LAG-1]
  // S_SEARCH  | per lag: N issues + 3 flush/compare cycles
  // S_DONE    | one-cycle done pulse, results already registered
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEARCH, S_DONE} state_t;

  localparam int NF = N + MAX_LAG;
  localparam int AW = $clog2(N);
  localparam int FW = $clog2(NF);
  localparam int CW = $clog2(N + 3);
  localparam logic signed [31:0] MOST_NEG = 32'sh8000_0000;

  state_t state_q, state_d;

  logic [FW-1:0]       cap_cnt_q, cap_cnt_d;
  logic [CW-1:0]       c_q, c_d;
  logic [7:0]          lag_q, lag_d;
  logic                rd_v_q, prod_v_q;
  logic [2*W-1:0]      ref_rd_q, fb_rd_q;
  logic signed [24:0]  prod_q, prod_d;
  logic signed [31:0]  acc_q, acc_d;
  logic signed [31:0]  best_q, best_d;
  logic [7:0]          best_lag_q, best_lag_d;
  logic [7:0]          delay_q, delay_d;
  logic signed [31:0]  peak_q, peak_d;
  logic                fail_q, fail_d;

  logic [2*W-1:0] ref_mem [N];
  logic [2*W-1:0] fb_mem  [NF];

  logic           cap_we, ref_we, issue, cap_last, lag_end, last_lag;
  logic [FW-1:0]  wr_addr, fb_addr;
  logic signed [31:0] new_best;
  logic [7:0]         new_lag;

  assign cap_last = (cap_cnt_q == FW'(NF - 1));
  assign lag_end  = (c_q == CW'(N + 2));
  assign last_lag = (lag_q == 8'(MAX_LAG));
  assign issue    = (state_q == S_SEARCH) && (c_q < CW'(N));
  assign cap_we   = ((state_q == S_IDLE) && est.start) || (state_q == S_CAPTURE);
  assign wr_addr  = (state_q == S_IDLE) ? '0 : cap_cnt_q;
  assign ref_we   = cap_we && ({1'b0, wr_addr} < (FW+1)'(N));
  assign fb_addr  = FW'(c_q) + FW'(lag_q);

  // strict compare: a tie never displaces an earlier lag
  assign new_best = (acc_q > best_q) ? acc_q : best_q;
  assign new_lag  = (acc_q > best_q) ? lag_q : best_lag_q;

  // Buffers: simple dual-port, registered read, no reset
  always_ff @(posedge clk) begin
    if (ref_we) ref_mem[wr_addr[AW-1:0]] <= {est.ref_i, est.ref_q};
    if (cap_we) fb_mem[wr_addr]          <= {est.fb_i, est.fb_q};
    if (issue) begin
      ref_rd_q <= ref_mem[c_q[AW-1:0]];
      fb_rd_q  <= fb_mem[fb_addr];
    end
  end

  logic signed [11:0] ri, rq, fi, fq;
  logic signed [23:0] m_i, m_q;
  assign ri     = ref_rd_q[2*W-1 -: 12];
  assign rq     = ref_rd_q[W-1   -: 12];
  assign fi     = fb_rd_q[2*W-1  -: 12];
  assign fq     = fb_rd_q[W-1    -: 12];
  assign m_i    = ri * fi;
  assign m_q    = rq * fq;
  assign prod_d = {m_i[23], m_i} + {m_q[23], m_q};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (est.start) state_d = S_CAPTURE;
      S_CAPTURE: if (cap_last) state_d = S_SEARCH;
      S_SEARCH:  if (lag_end && last_lag) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    est.busy = (state_q == S_CAPTURE) || (state_q == S_SEARCH);
    est.done = (state_q == S_DONE);
  end

  always_comb begin
    cap_cnt_d  = cap_cnt_q;
    c_d        = c_q;
    lag_d      = lag_q;
    acc_d      = acc_q;
    best_d     = best_q;
    best_lag_d = best_lag_q;
    delay_d    = delay_q;
    peak_d     = peak_q;
    fail_d     = fail_q;
    case (state_q)
      S_IDLE: begin
        cap_cnt_d  = FW'(1);
        c_d        = '0;
        lag_d      = '0;
        acc_d      = '0;
        best_d     = MOST_NEG;
        best_lag_d = '0;
      end
      S_CAPTURE: cap_cnt_d = cap_cnt_q + FW'(1);
      S_SEARCH: begin
        if (prod_v_q) acc_d = acc_q + {{7{prod_q[24]}}, prod_q};
        if (lag_end) begin
          c_d        = '0;
          lag_d      = lag_q + 8'd1;
          acc_d      = '0;
          best_d     = new_best;
          best_lag_d = new_lag;
          if (last_lag) begin
            peak_d = new_best;
            if (new_best >= THRESH) begin
              delay_d = new_lag;
              fail_d  = 1'b0;
            end else begin
              fail_d  = 1'b1;
            end
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cap_cnt_q  <= '0;
      c_q        <= '0;
      lag_q      <= '0;
      rd_v_q     <= 1'b0;
      prod_v_q   <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      best_q     <= MOST_NEG;
      best_lag_q <= '0;
      delay_q    <= 8'(DEFAULT_DELAY);
      peak_q     <= '0;
      fail_q     <= 1'b0;
    end else begin
      cap_cnt_q  <= cap_cnt_d;
      c_q        <= c_d;
      lag_q      <= lag_d;
      rd_v_q     <= issue;
      prod_v_q   <= rd_v_q;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_lag_q <= best_lag_d;
      delay_q    <= delay_d;
      peak_q     <= peak_d;
      fail_q     <= fail_d;
    end
  end

  assign est.delay_out = delay_q;
  assign est.peak_out  = peak_q;
  assign est.fail      = fail_q;
endmodule

// File: tb/tb_dpd_delay_est.sv
// Directed bench for dpd_delay_est: expected results are queued at start and
// checked by a monitor when done pulses.
module tb_dpd_delay_est;
  localparam int W       = 20;
  localparam int N       = 64;
  localparam int MAX_LAG = 63;
  localparam int NF      = N + MAX_LAG;
  localparam int LAT     = NF + (MAX_LAG + 1) * (N + 3);
  localparam logic signed [31:0] PK = 32'sd134217728;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  dpd_delay_est_if #(.W(W)) bus();

  dpd_delay_est #(.W(W), .N(N), .MAX_LAG(MAX_LAG), .DEFAULT_DELAY(41), .THRESH(32'sd1)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .est     (bus)
  );

  typedef struct {
    int                 cyc;
    logic [7:0]         delay;
    logic               fail;
    logic signed [31:0] peak;
    string              name;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic s_i [NF + MAX_LAG];
  logic s_q [NF + MAX_LAG];
  logic [15:0] pat_i = 16'b1011001011100001;
  logic [15:0] pat_q = 16'b0110100111000111;

  task automatic check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] qpsk(input logic b);
    return b ? 20'h40000 : 20'hC0000;
  endfunction

  // done cycle is counted by the negedge inside that cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_cycle"}, cyc, e.cyc);
          check({e.name, "_delay"}, bus.delay_out, e.delay);
          check({e.name, "_fail"}, bus.fail, e.fail);
          check({e.name, "_peak"}, bus.peak_out, e.peak);
          check({e.name, "_busy_at_done"}, bus.busy, 0);
        end
      end
    end
  end

  task automatic drive(input int mode, input int dly, input int k);
    if (k >= NF) begin
      bus.ref_i = '0; bus.ref_q = '0; bus.fb_i = '0; bus.fb_q = '0;
    end else if (mode == 2) begin
      bus.ref_i = qpsk(pat_i[k % 16]);
      bus.ref_q = qpsk(pat_q[k % 16]);
      bus.fb_i  = qpsk(pat_i[(k - dly + 160) % 16]);
      bus.fb_q  = qpsk(pat_q[(k - dly + 160) % 16]);
    end else begin
      bus.ref_i = qpsk(s_i[k + MAX_LAG]);
      bus.ref_q = qpsk(s_q[k + MAX_LAG]);
      if (mode == 1) begin
        bus.fb_i = '0;
        bus.fb_q = '0;
      end else begin
        bus.fb_i = qpsk(s_i[k - dly + MAX_LAG]);
        bus.fb_q = qpsk(s_q[k - dly + MAX_LAG]);
      end
    end
  endtask

  task automatic run(input string nm, input int mode, input int dly, input bit push,
                     input logic [7:0] e_delay, input logic e_fail, input logic signed [31:0] e_peak,
                     input int p1, input int p2, input int rst_at);
    int   t0;
    exp_t e;
    @(posedge clk); #1;
    t0 = cyc + 1;
    if (push) begin
      e.cyc = t0 + LAT; e.delay = e_delay; e.fail = e_fail; e.peak = e_peak; e.name = nm;
      sb.push_back(e);
    end
    for (int k = 0; k < LAT + 50; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == rst_at) begin
        bus.start = 1'b0;
        reset_b = 1'b0;
        #1;
        check({nm, "_rst_busy"}, bus.busy, 0);
        check({nm, "_rst_done"}, bus.done, 0);
        check({nm, "_rst_delay"}, bus.delay_out, 41);
        check({nm, "_rst_peak"}, bus.peak_out, 0);
        check({nm, "_rst_fail"}, bus.fail, 0);
        @(posedge clk); #1;
        reset_b = 1'b1;
        repeat (1500) @(posedge clk);
        return;
      end
      bus.start = (k == 0) || (k == p1) || (k == p2);
      drive(mode, dly, k);
      if (k == 1 || k == p1 || k == p2) check({nm, "_busy"}, bus.busy, 1);
      if (rst_at < 0 && k > NF && sb.size() == 0) break;
    end
    bus.start = 1'b0;
    if (sb.size() != 0) begin
      check({nm, "_done_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin : stim
    logic [15:0] lfsr;
    lfsr = 16'hACE1;
    for (int j = 0; j < NF + MAX_LAG; j++) begin
      s_i[j] = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      s_q[j] = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    bus.start = 1'b0;
    drive(0, 0, NF);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_fail", bus.fail, 0);
    check("reset_delay", bus.delay_out, 41);
    check("reset_peak", bus.peak_out, 0);
    reset_b = 1'b1;

    run("t1_d41",     0, 41, 1'b1, 8'd41, 1'b0, PK,    -1,   -1,   -1);
    run("t3_fb0",     1, 41, 1'b1, 8'd41, 1'b1, 32'sd0, -1,  -1,   -1);
    run("t2_d0",      0,  0, 1'b1, 8'd0,  1'b0, PK,    -1,   -1,   -1);
    run("t2_d63",     0, 63, 1'b1, 8'd63, 1'b0, PK,    -1,   -1,   -1);
    run("t5_restart", 0, 41, 1'b1, 8'd41, 1'b0, PK,    100, 2000,  -1);
    run("t4_period",  2,  5, 1'b1, 8'd5,  1'b0, PK,    -1,   -1,   -1);
    run("t6_abort",   0, 20, 1'b0, 8'd0,  1'b0, 32'sd0, -1,  -1, 3000);
    run("t6_rerun",   0, 17, 1'b1, 8'd17, 1'b0, PK,    -1,   -1,   -1);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
